// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared widths and the round-robin pick helper for ROM arbitration.
package rom_arbiter_pkg;
  localparam int ROM_ADDR_WIDTH = 4;
  localparam int ROM_DATA_WIDTH = 4;
  localparam int STATS_COUNT_WIDTH = 8;

  // Sized for the largest supported arbiter (8 requesters); n trims it to the real count.
  function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
    logic [7:0] g;
    logic found;
    int idx;
    g = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && valid[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/rom_arbiter_rr_grant.sv
// rr_grant: combinational round-robin grant with a registered rotating priority pointer.
module rr_grant
  import rom_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt;
  logic [7:0]    pick;
  always_comb begin
    pick = rr_pick(8'(valid), 3'(ptr), N);
    grant = pick[N-1:0];
    nxt = ptr;
    for (int k = 0; k < N; k++)
      if (grant[k]) nxt = (k == N - 1) ? '0 : PW'(k + 1);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (|valid) ptr <= nxt;
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one 1-cycle-latency ROM among NUM_REQ requesters.
// Optional per-requester saturating grant counters under `ROM_ARBITER_STATS_EN.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROM_DATA_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          rom_enable,
  output logic [ADDR_WIDTH-1:0]         rom_address,
`ifdef ROM_ARBITER_STATS_EN
  input  logic                                 stats_clear,
  output logic [NUM_REQ*STATS_COUNT_WIDTH-1:0] grant_count,
`endif
  input  logic [DATA_WIDTH-1:0]         rom_read_data
);
  logic [NUM_REQ-1:0] pend_tag;

  rr_grant #(.N(NUM_REQ)) u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (req_valid),
    .grant   (req_ready)
  );

  always_comb begin
    rom_address = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) rom_address = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign rom_enable = |req_ready;
  assign resp_valid = pend_tag;
  // The ROM drives garbage when not enabled, so only pass data through with a live tag.
  assign resp_data  = (|pend_tag) ? rom_read_data : '0;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) pend_tag <= '0;
    else pend_tag <= req_ready;

`ifdef ROM_ARBITER_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [STATS_COUNT_WIDTH-1:0] cnt;
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (stats_clear) cnt <= '0;
      else if (req_ready[g] && cnt != '1) cnt <= cnt + 1'b1;
    assign grant_count[g*STATS_COUNT_WIDTH +: STATS_COUNT_WIDTH] = cnt;
  end
`endif
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed checks of rom_arbiter against a queue-free behavioural model and an identity ROM.
module tb_rom_arbiter;
  localparam int N = 4;
  localparam int AW = 4;
  localparam int DW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  resp_valid;
  logic [DW-1:0] resp_data;
  logic          rom_enable;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_read_data = 4'hA;
`ifdef ROM_ARBITER_STATS_EN
  logic            stats_clear = 1'b0;
  logic [N*8-1:0]  grant_count;
`endif

  int total = 0;
  int bad = 0;
  bit run = 1'b0;

  int   m_ptr = 0;
  int   m_tag = 0;
  int   m_data = 0;

  rom_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .rom_enable    (rom_enable),
    .rom_address   (rom_address),
`ifdef ROM_ARBITER_STATS_EN
    .stats_clear   (stats_clear),
    .grant_count   (grant_count),
`endif
    .rom_read_data (rom_read_data)
  );

  always #5 clock = ~clock;

  function automatic int rom_word(input int a);
    return a % 16;
  endfunction

  // Identity ROM; drives a non-zero junk word when not enabled so masking is visible.
  always @(posedge clock) rom_read_data <= rom_enable ? 4'(rom_word(int'(rom_address))) : 4'hA;

  function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int addr_of(input int g);
    return int'(req_addr[g*AW +: AW]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    int g;
    if (!reset_n) begin
      m_ptr = 0;
      m_tag = 0;
      m_data = 0;
    end else begin
      g = exp_grant(req_valid, m_ptr);
      if (g >= 0) begin
        m_tag = 1 << g;
        m_data = rom_word(addr_of(g));
        m_ptr = (g + 1) % N;
      end else begin
        m_tag = 0;
        m_data = 0;
      end
    end
  end

  always @(negedge clock) begin
    int g;
    if (run) begin
      g = exp_grant(req_valid, m_ptr);
      chk("req_ready", int'(req_ready), g < 0 ? 0 : (1 << g));
      chk("rom_enable", int'(rom_enable), g >= 0 ? 1 : 0);
      chk("rom_address", int'(rom_address), g < 0 ? 0 : addr_of(g));
      chk("resp_valid", int'(resp_valid), m_tag);
      chk("resp_data", int'(resp_data), m_tag != 0 ? m_data : 0);
    end
  end

  task automatic cyc(input logic [N-1:0] v, input logic [N*AW-1:0] a);
    @(posedge clock);
    #1;
    req_valid = v;
    req_addr = a;
    @(negedge clock);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    run = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset resp_valid", int'(resp_valid), 0);
    chk("reset req_ready", int'(req_ready), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // All valid from reset: grants 0,1,2,3,0 with data 3,5,7,11,3 one cycle later.
    cyc(4'b1111, 16'hB753);
    chk("rot0 ready", int'(req_ready), 1);
    chk("rot0 addr", int'(rom_address), 3);
    cyc(4'b1111, 16'hB753);
    chk("rot1 ready", int'(req_ready), 2);
    chk("rot1 resp", int'(resp_data), 3);
    cyc(4'b1111, 16'hB753);
    chk("rot2 ready", int'(req_ready), 4);
    chk("rot2 resp", int'(resp_data), 5);
    cyc(4'b1111, 16'hB753);
    chk("rot3 ready", int'(req_ready), 8);
    chk("rot3 resp_valid", int'(resp_valid), 4);
    cyc(4'b1111, 16'hB753);
    chk("rot4 ready", int'(req_ready), 1);
    chk("rot4 resp", int'(resp_data), 11);

    // Two idle cycles: enable drops, then the response slot empties with data masked.
    cyc(4'b0000, 16'h0000);
    chk("idle enable", int'(rom_enable), 0);
    chk("idle last resp", int'(resp_data), 3);
    cyc(4'b0000, 16'h0000);
    chk("idle resp_valid", int'(resp_valid), 0);
    chk("idle resp_data", int'(resp_data), 0);

    // Rotation resumes at requester 1; then 1 and 3 valid with pointer at 2.
    cyc(4'b1111, 16'h4321);
    chk("resume ready", int'(req_ready), 2);
    cyc(4'b1010, 16'hD0E0);
    chk("wrap ready3", int'(req_ready), 8);
    cyc(4'b1010, 16'hD0E0);
    chk("wrap ready1", int'(req_ready), 2);
    chk("wrap resp", int'(resp_data), 13);

    // Single requester 2 at address 9.
    cyc(4'b0100, 16'h0900);
    chk("single ready", int'(req_ready), 4);
    chk("single addr", int'(rom_address), 9);
    cyc(4'b0000, 16'h0000);
    chk("single resp_valid", int'(resp_valid), 4);
    chk("single resp", int'(resp_data), 9);

    // A grant, then reset in the following cycle discards its response.
    cyc(4'b1111, 16'h5555);
    chk("pre-reset ready", int'(req_ready), 8);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    req_valid = '0;
    #1;
    chk("reset kills resp", int'(resp_valid), 0);
    @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    cyc(4'b1111, 16'h2468);
    chk("post-reset ready", int'(req_ready), 1);

    for (int i = 0; i < 40; i++)
      cyc(4'($urandom_range(0, 15)), 16'($urandom));

`ifdef ROM_ARBITER_STATS_EN
    @(posedge clock);
    #1 reset_n = 1'b0;
    req_valid = '0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 300; i++) cyc(4'b0001, 16'h0007);
    cyc(4'b0000, 16'h0000);
    chk("stats sat", int'(grant_count[7:0]), 255);
    chk("stats other", int'(grant_count[15:8]), 0);
    @(posedge clock);
    #1 stats_clear = 1'b1;
    req_valid = 4'b0001;
    @(posedge clock);
    #1 stats_clear = 1'b0;
    req_valid = '0;
    @(negedge clock);
    chk("stats clear", int'(grant_count[7:0]), 0);
`endif

    @(posedge clock);
    #1 run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Round-robin arbiter that shares one synchronous 1-cycle-latency ROM (enable/address/read_data interface) between NUM_REQ requesters.
- Accepts at most one read per cycle via a valid/ready handshake and drives the ROM's enable and address.
- Routes the returned word back to the originating requester with a one-hot response-valid tag.
- Sits between the lookup-table ROM and its client blocks.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 4, ROM address width.
- DATA_WIDTH, 4, ROM data width.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester read request.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  output  NUM_REQ  one-hot grant; a request is accepted when valid and ready are both high.
- resp_valid  output  NUM_REQ  one-hot; response for requester i is on resp_data this cycle.
- resp_data  output  DATA_WIDTH  read word, shared by all requesters.
- rom_enable  output  1  to ROM enable.
- rom_address  output  ADDR_WIDTH  to ROM address.
- rom_read_data  input  DATA_WIDTH  from ROM read_data; valid one cycle after an enabled edge.

Behaviour:
- Reset (async assert, sync deassert): rr_ptr=0, pend_tag=0, resp_valid=0. req_ready, rom_enable, rom_address and resp_data are derived and therefore 0 during reset.
- Arbitration is combinational each cycle:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit i wins.
  - req_ready = one-hot(i); rom_enable=1; rom_address=req_addr[i].
  - If no request is valid: req_ready=0, rom_enable=0, rom_address=0.
- req_ready never depends on downstream backpressure; responses cannot be stalled.
- On an accepted cycle, at the clock edge:
  - rr_ptr <= (i+1) mod NUM_REQ.
  - pend_tag <= one-hot(i).
- On an idle cycle, rr_ptr is held and pend_tag <= 0.
- Response timing:
  - resp_valid = pend_tag (registered).
  - resp_data = rom_read_data when resp_valid is nonzero, else 0. This masks the X the ROM drives when disabled.
  - Latency from handshake edge to resp_valid is exactly 1 cycle.
  - Throughput is 1 read/cycle; back-to-back grants are pipelined.
- Fairness: a continuously asserting requester is granted at least once every NUM_REQ cycles.
- A requester may keep req_valid high with a changing address. Each accepted cycle is an independent read.
- Simultaneous all-valid: grants rotate 0,1,2,3,0,... from reset.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation: the in-flight response is discarded (resp_valid=0 immediately) and arbitration restarts at requester 0.

Optional Feature:
- Macro: ROM_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_count, NUM_REQ*8 bits, packed 8-bit per-requester counters.
  - Each counter increments on every accepted handshake for its requester and saturates at 255.
  - Adds input stats_clear (1 bit); synchronous clear to 0, which takes priority over increment in the same cycle.
  - Counters reset to 0 on reset_n.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rom_arbiter_pkg:
  - Constants ROM_ADDR_WIDTH=4, ROM_DATA_WIDTH=4, STATS_COUNT_WIDTH=8.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
- One sub-module, rr_grant: combinational priority rotation plus registered rr_ptr, reused by other shared-resource arbiters.

Test Plan:
- Single requester: req_valid=4'b0100, req_addr[2]=9 -> req_ready=4'b0100 same cycle; rom_enable=1, rom_address=9; next cycle resp_valid=4'b0100, resp_data=9 (identity ROM contents).
- All four valid continuously, addresses 3,5,7,11 -> grants 0,1,2,3,0 on consecutive cycles; resp_data 3,5,7,11,3 each one cycle later with the matching resp_valid bit.
- Idle cycle between requests -> rom_enable=0 and resp_valid=0 one cycle later; resp_data=0; rr_ptr unchanged (next grant continues rotation).
- Requesters 1 and 3 valid with rr_ptr=2 -> requester 3 granted, then 1; rr_ptr wraps 3->0.
- Assert reset_n=0 in the cycle after a grant -> resp_valid=0 immediately, no response delivered; after release with all valid, requester 0 is granted first.
- With ROM_ARBITER_STATS_EN: requester 0 granted 300 times -> grant_count[7:0]=255; stats_clear pulse -> 0 next cycle.
